// File: rtl/search_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : search_pkg
//  Description : Shared types and default widths for the search request
//                scheduler and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package search_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  // Default key/RAM word width and RAM address (result index) width
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

endpackage : search_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or after ptr, wrapping around N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  // One extra bit so ptr+offset never overflows before the wrap subtract
  logic [IDX_W:0] w_pos;
  logic           w_hit;

  // Scan requesters starting at ptr; the first pending one wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    w_hit = 1'b0;
    w_pos = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(N_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(N_REQ);
      end
      if (!w_hit && req[w_pos[IDX_W-1:0]]) begin
        w_hit                 = 1'b1;
        idx                   = w_pos[IDX_W-1:0];
        gnt[w_pos[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/search_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : search_req_scheduler
//  Description : Shares one binary-search engine between N_REQ requesters.
//                Round-robin grant in IDLE, key latched and held for the whole
//                search, result returned as a one-cycle registered ack pulse,
//                then the engine is drained back to idle before the next grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module search_req_scheduler
  import search_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 64            // must be >= 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   key,
  output logic [N_REQ-1:0]          ack,
  output logic                      resp_found,
  output logic [ADDR_W-1:0]         resp_addr,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_key,
  input  logic                      eng_found,
  input  logic                      eng_not_found,
  input  logic [ADDR_W-1:0]         eng_addr
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_key;
  logic               r_found;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_err;

  logic [N_REQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [DATA_W-1:0]  w_key;
  logic [N_REQ-1:0]   w_resp_oh;
  logic               w_done;
  logic               w_hit;
  logic               w_tmo;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx)
  );

  // Either done flag ends the search; both together count as a miss
  assign w_done    = eng_found | eng_not_found;
  assign w_hit     = eng_found & ~eng_not_found;
  assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_resp_oh = N_REQ'(1) << r_gnt_idx;
  assign eng_key   = r_key;

  // Key of the granted requester, selected by the one-hot grant
  always_comb begin
    w_key = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_key = w_key | key[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and engine handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    eng_start   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (|req) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        eng_start = 1'b1;
        if (w_done || w_tmo) w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!w_done) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant/key latch, timeout counter, result capture and registered response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_cnt      <= '0;
      r_key      <= '0;
      r_found    <= 1'b0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      ack        <= '0;
      resp_found <= 1'b0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Response outputs are a single-cycle pulse and read 0 otherwise
      ack        <= '0;
      resp_found <= 1'b0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt_idx <= w_arb_idx;
            r_key     <= w_key;
            r_cnt     <= '0;
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A completion in the expiry cycle still wins over the timeout
          if (w_done) begin
            r_found <= w_hit;
            r_addr  <= w_hit ? eng_addr : '0;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_found <= 1'b0;
            r_addr  <= '0;
            r_err   <= 1'b1;
          end
        end
        RESP: begin
          // A requester that withdrew gets no ack but still loses its turn
          if (req[r_gnt_idx]) begin
            ack        <= w_resp_oh;
            resp_found <= r_found;
            resp_addr  <= r_addr;
            resp_err   <= r_err;
          end
          r_ptr <= (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule : search_req_scheduler
`default_nettype wire

// File: tb/tb_search_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_search_req_scheduler
//  Description : Self-checking bench for search_req_scheduler with a
//                behavioural search engine over a sorted 32x8 RAM image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_search_req_scheduler;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 3;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] key;
  logic [N_REQ-1:0]        ack;
  logic                    resp_found;
  logic [ADDR_W-1:0]       resp_addr;
  logic                    resp_err;
  logic                    busy;
  logic                    eng_start;
  logic [DATA_W-1:0]       eng_key;
  logic                    eng_found = 1'b0;
  logic                    eng_not_found = 1'b0;
  logic [ADDR_W-1:0]       eng_addr = '0;

  int n_checks = 0;
  int n_err    = 0;
  int n_acks   = 0;
  int run_len  = 0;
  int last_run = 0;
  int m_cnt    = 0;
  bit hang     = 1'b0;
  bit both     = 1'b0;
  logic [7:0] ram [32];

  search_req_scheduler #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .key           (key),
    .ack           (ack),
    .resp_found    (resp_found),
    .resp_addr     (resp_addr),
    .resp_err      (resp_err),
    .busy          (busy),
    .eng_start     (eng_start),
    .eng_key       (eng_key),
    .eng_found     (eng_found),
    .eng_not_found (eng_not_found),
    .eng_addr      (eng_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [7:0] k, output logic [4:0] idx);
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (ram[i] == k) begin
        idx = 5'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Behavioural engine: done after LAT start cycles, held until start drops
  always @(posedge clk) begin
    logic [4:0] idx;
    bit         hit;
    if (!eng_start) begin
      eng_found     <= 1'b0;
      eng_not_found <= 1'b0;
      eng_addr      <= '0;
      m_cnt         <= 0;
    end else if (m_cnt != LAT) begin
      m_cnt <= m_cnt + 1;
    end else if (!hang) begin
      hit = lookup(eng_key, idx);
      if (both) begin
        eng_found     <= 1'b1;
        eng_not_found <= 1'b1;
        eng_addr      <= idx;
      end else if (hit) begin
        eng_found <= 1'b1;
        eng_addr  <= idx;
      end else begin
        eng_not_found <= 1'b1;
        eng_addr      <= 5'h15;   // junk: must not leak to resp_addr
      end
    end
  end

  // Background checks: idle response is zero, acks are one-hot
  always @(negedge clk) begin
    if (eng_start) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (reset_n) begin
      if (ack == '0) chk("resp_idle", {resp_found, resp_addr, resp_err}, 0);
      else begin
        n_acks++;
        chk("ack_onehot", $countones(ack), 1);
      end
    end
  end

  task automatic set_keys(input logic [7:0] k0, k1, k2, k3);
    key = {k3, k2, k1, k0};
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eng_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("start_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] rq;
    logic [7:0] k;
    bit         hng;
    bit         bth;
    logic [3:0] e_ack;
    logic       e_found;
    logic [4:0] e_addr;
    logic       e_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acks_before;

    for (int i = 0; i < 32; i++) ram[i] = 8'(i * 4);

    //            req      key    hang  both  ack      found addr   err
    vt[0] = '{4'b0001, 8'h0C, 1'b0, 1'b0, 4'b0001, 1'b1, 5'd3,  1'b0};
    vt[1] = '{4'b0010, 8'hFF, 1'b0, 1'b0, 4'b0010, 1'b0, 5'd0,  1'b0};
    vt[2] = '{4'b0100, 8'h40, 1'b0, 1'b0, 4'b0100, 1'b1, 5'd16, 1'b0};
    vt[3] = '{4'b1000, 8'h7C, 1'b0, 1'b0, 4'b1000, 1'b1, 5'd31, 1'b0};
    vt[4] = '{4'b0001, 8'h00, 1'b0, 1'b0, 4'b0001, 1'b1, 5'd0,  1'b0};
    vt[5] = '{4'b0001, 8'h7D, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd0,  1'b0};
    vt[6] = '{4'b0010, 8'h20, 1'b1, 1'b0, 4'b0010, 1'b0, 5'd0,  1'b1};
    vt[7] = '{4'b0100, 8'h0C, 1'b0, 1'b1, 4'b0100, 1'b0, 5'd0,  1'b0};

    reset_n = 1'b0;
    req     = '0;
    key     = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {ack, resp_found, resp_addr, resp_err, busy, eng_start, eng_key}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single-requester searches
    for (int v = 0; v < 8; v++) begin
      hang = vt[v].hng;
      both = vt[v].bth;
      set_keys(vt[v].k, vt[v].k, vt[v].k, vt[v].k);
      req = vt[v].rq;
      @(negedge clk);
      chk($sformatf("v%0d_start_lat", v), eng_start, 1);
      chk($sformatf("v%0d_key", v), eng_key, vt[v].k);
      wait_ack(ok);
      if (ok) begin
        chk($sformatf("v%0d_ack", v), ack, vt[v].e_ack);
        chk($sformatf("v%0d_found", v), resp_found, vt[v].e_found);
        chk($sformatf("v%0d_addr", v), resp_addr, vt[v].e_addr);
        chk($sformatf("v%0d_err", v), resp_err, vt[v].e_err);
        chk($sformatf("v%0d_start_low", v), eng_start, 0);
        if (vt[v].hng) chk($sformatf("v%0d_tmo_len", v), last_run, TIMEOUT);
      end
      req  = '0;
      hang = 1'b0;
      both = 1'b0;
      wait_idle();
    end

    // Round robin with all four held: order 0,1,2,3,0 from a fresh pointer
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_keys(8'h0C, 8'h20, 8'h40, 8'h7C);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [3:0] exp_oh;
      logic [4:0] exp_a;
      exp_oh = 4'b0001 << (n % 4);
      case (n % 4)
        0: exp_a = 5'd3;
        1: exp_a = 5'd8;
        2: exp_a = 5'd16;
        default: exp_a = 5'd31;
      endcase
      wait_ack(ok);
      if (ok) begin
        chk($sformatf("rr%0d_ack", n), ack, exp_oh);
        chk($sformatf("rr%0d_addr", n), resp_addr, exp_a);
      end
    end
    req = '0;
    wait_idle();

    // Move the pointer to 2, then reset in the middle of a hung search
    req = 4'b0010;
    wait_ack(ok);
    if (ok) chk("pre_rst_ack", ack, 4'b0010);
    req = '0;
    wait_idle();
    hang = 1'b1;
    req  = 4'b0100;
    wait_start(ok);
    repeat (5) @(negedge clk);
    acks_before = n_acks;
    #2 reset_n = 1'b0;
    #1 chk("rst_async", {ack, resp_found, resp_addr, resp_err, busy, eng_start, eng_key}, 0);
    @(negedge clk);
    hang = 1'b0;
    req  = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_ack", n_acks, acks_before);
    req = 4'b1001;
    wait_ack(ok);
    if (ok) chk("post_rst_ptr0", ack, 4'b0001);
    req = '0;
    wait_idle();

    // Requester 2 withdraws during ISSUE: no ack, requester 3 served next
    req = 4'b1100;
    wait_start(ok);
    req = 4'b1011;
    wait_ack(ok);
    if (ok) begin
      chk("drop_next_ack", ack, 4'b1000);
      chk("drop_next_addr", resp_addr, 5'd31);
    end
    req = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_search_req_scheduler
`default_nettype wire
